rggen_apb_irq_block: RTL and testbench

Parametrised APB register block providing CHANNELS interrupt channels. Each channel has a sticky write-1-to-clear (W1C) event status register, a read/write enable mask and a registered interrupt output; a global read-only pending summary register follows them. The block sits between an APB bridge and peripheral event sources. It includes its own APB slave state machine with one fixed wait state.

---
 rtl/rggen_apb_irq_block.sv | 176 +++++++++++++++++
 tb/tb_rggen_apb_irq_block.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rggen_apb_irq_block.sv
// APB register block: per-channel sticky W1C event status, enable mask and
// registered interrupt outputs, followed by a read-only pending summary.
module rggen_apb_irq_block #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned EVENT_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_psel,
  input  logic                            i_penable,
  input  logic                            i_pwrite,
  input  logic [ADDRESS_WIDTH-1:0]        i_paddr,
  input  logic [DATA_WIDTH-1:0]           i_pwdata,
  output logic                            o_pready,
  output logic [DATA_WIDTH-1:0]           o_prdata,
  output logic                            o_pslverr,
  input  logic [CHANNELS*EVENT_WIDTH-1:0] i_event,
  output logic [CHANNELS-1:0]             o_irq,
  output logic                            o_irq_any
);

  localparam int unsigned CH_IDX_W = ADDRESS_WIDTH - 3;
  localparam int unsigned WADDR_W  = ADDRESS_WIDTH - 2;
  localparam logic [ADDRESS_WIDTH-1:0] PENDING_ADDR = ADDRESS_WIDTH'(8 * CHANNELS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e                               state_q, state_d;
  logic                                 pready_q, pready_d;
  logic [DATA_WIDTH-1:0]                prdata_q, prdata_d;
  logic                                 pslverr_q, pslverr_d;
  logic                                 wr_q, wr_d;
  logic [WADDR_W-1:0]                   waddr_q, waddr_d;
  logic [EVENT_WIDTH-1:0]               wdata_q, wdata_d;
  logic [CHANNELS-1:0][EVENT_WIDTH-1:0] status_q, status_d;
  logic [CHANNELS-1:0][EVENT_WIDTH-1:0] enable_q, enable_d;
  logic [CHANNELS-1:0][EVENT_WIDTH-1:0] w1c_clr;
  logic [CHANNELS-1:0]                  irq_q, irq_d;
  logic                                 irq_any_q, irq_any_d;

  logic                                 dec_pending;
  logic                                 dec_err;
  logic [DATA_WIDTH-1:0]                dec_rdata;
  logic                                 commit;
  logic                                 unused_pwdata;

  // Only the low EVENT_WIDTH bits of write data are ever stored.
  always_comb begin
    unused_pwdata = ^i_pwdata;
  end

  // Address decode and read mux for the access currently on the bus.
  always_comb begin
    dec_pending = (i_paddr == PENDING_ADDR);
    dec_err     = (i_paddr[1:0] != 2'b00) || (i_paddr > PENDING_ADDR) ||
                  (dec_pending && i_pwrite);
    dec_rdata   = '0;
    if (dec_pending) begin
      dec_rdata = DATA_WIDTH'(irq_q);
    end
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (i_paddr[ADDRESS_WIDTH-1:3] == CH_IDX_W'(c)) begin
        dec_rdata = i_paddr[2] ? DATA_WIDTH'(enable_q[c]) : DATA_WIDTH'(status_q[c]);
      end
    end
  end

  // APB slave FSM: setup -> one wait state -> one ready cycle.
  always_comb begin
    state_d   = state_q;
    pready_d  = 1'b0;
    prdata_d  = '0;
    pslverr_d = 1'b0;
    wr_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (i_psel && !i_penable) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!i_psel) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_DONE;
          pready_d  = 1'b1;
          pslverr_d = dec_err;
          prdata_d  = (dec_err || i_pwrite) ? '0 : dec_rdata;
          wr_d      = i_pwrite && !dec_err;
          waddr_d   = i_paddr[ADDRESS_WIDTH-1:2];
          wdata_d   = i_pwdata[EVENT_WIDTH-1:0];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pready_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      wr_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pready_q  <= pready_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
      wr_q      <= wr_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  // A valid write takes effect on the edge that leaves DONE.
  always_comb begin
    commit = wr_q && (state_q == ST_DONE);
  end

  // Register file: new events win over a simultaneous W1C clear.
  always_comb begin
    enable_d = enable_q;
    status_d = status_q;
    w1c_clr  = '0;
    irq_d    = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (commit && (waddr_q[WADDR_W-1:1] == CH_IDX_W'(c))) begin
        if (waddr_q[0]) begin
          enable_d[c] = wdata_q;
        end else begin
          w1c_clr[c] = wdata_q;
        end
      end
      status_d[c] = i_event[c*EVENT_WIDTH +: EVENT_WIDTH] | (status_q[c] & ~w1c_clr[c]);
      irq_d[c]    = |(status_q[c] & enable_q[c]);
    end
    irq_any_d = |irq_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q  <= '0;
      enable_q  <= '0;
      irq_q     <= '0;
      irq_any_q <= 1'b0;
    end else begin
      status_q  <= status_d;
      enable_q  <= enable_d;
      irq_q     <= irq_d;
      irq_any_q <= irq_any_d;
    end
  end

  assign o_pready  = pready_q;
  assign o_prdata  = prdata_q;
  assign o_pslverr = pslverr_q;
  assign o_irq     = irq_q;
  assign o_irq_any = irq_any_q;

endmodule

// File: tb/tb_rggen_apb_irq_block.sv
// Self-checking bench for rggen_apb_irq_block: directed vector table,
// hand-written corner sequences and a randomized phase against a register model.
module tb_rggen_apb_irq_block;

  localparam int unsigned CH = 4;
  localparam int unsigned EW = 8;
  localparam int NV = 23;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [31:0] i_event = '0;
  logic [3:0]  irq;
  logic        irq_any;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  bit [EW-1:0] m_status [CH];
  bit [EW-1:0] m_enable [CH];
  bit [CH-1:0] m_irq;
  bit [CH-1:0] m_nirq;
  bit [EW-1:0] m_clr;
  bit          cm_valid = 1'b0;
  logic [7:0]  cm_addr = '0;
  logic [31:0] cm_data = '0;
  logic [31:0] ev_dir = '0;
  bit          rand_ev = 1'b0;
  bit          chk_en = 1'b0;

  typedef struct {
    bit          w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs [NV];

  rggen_apb_irq_block #(
    .CHANNELS(4), .EVENT_WIDTH(8), .DATA_WIDTH(32), .ADDRESS_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
    .i_paddr(paddr), .i_pwdata(pwdata),
    .o_pready(pready), .o_prdata(prdata), .o_pslverr(pslverr),
    .i_event(i_event), .o_irq(irq), .o_irq_any(irq_any)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Expected APB response from the register map rules.
  function automatic void m_access(input bit w, input logic [7:0] a,
                                   output bit err, output logic [31:0] rd);
    int unsigned ai = a;
    err = (ai % 4 != 0) || (ai > 8 * CH) || (w && ai == 8 * CH);
    rd  = '0;
    if (!err && !w) begin
      if (ai == 8 * CH)      rd = 32'(m_irq);
      else if (ai % 8 == 4)  rd = 32'(m_enable[ai / 8]);
      else                   rd = 32'(m_status[ai / 8]);
    end
  endfunction

  // Register model: sticky events, W1C clears, irq one edge behind status/enable.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        m_status[c] = '0;
        m_enable[c] = '0;
      end
      m_irq = '0;
    end else begin
      for (int c = 0; c < CH; c++) m_nirq[c] = |(m_status[c] & m_enable[c]);
      for (int c = 0; c < CH; c++) begin
        m_clr = '0;
        if (cm_valid && int'(cm_addr) / 8 == c) begin
          if (int'(cm_addr) % 8 == 4) m_enable[c] = cm_data[EW-1:0];
          else                        m_clr = cm_data[EW-1:0];
        end
        m_status[c] = i_event[c*EW +: EW] | (m_status[c] & ~m_clr);
      end
      m_irq = m_nirq;
    end
  end

  // Event driver: directed pulses, optionally overlaid with random sparse events.
  initial forever begin
    @(negedge clk);
    #2;
    if (rand_ev && $urandom_range(0, 3) == 0) i_event = ev_dir | ($urandom & $urandom);
    else                                      i_event = ev_dir;
  end

  // Continuous output checks against the model.
  initial forever begin
    @(negedge clk);
    if (rst_n && chk_en) begin
      check("irq", 32'(irq), 32'(m_irq));
      check("irq_any", 32'(irq_any), 32'(|m_irq));
      if (!pready) begin
        check("prdata_idle", prdata, 32'h0);
        check("pslverr_idle", 32'(pslverr), 32'h0);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: summary not reached, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // One APB transfer, entered and left at a negedge; back-to-back when chained.
  task automatic apb_xfer(input bit w, input logic [7:0] a, input logic [31:0] d,
                          input logic [31:0] ev_cmt,
                          output logic [31:0] rd, output bit err,
                          output bit x_err, output logic [31:0] x_rd);
    int waits;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(posedge clk); @(negedge clk);
    penable = 1'b1;
    check("pready_wait", 32'(pready), 32'h0);
    m_access(w, a, x_err, x_rd);
    waits = 0;
    do begin
      @(posedge clk); @(negedge clk);
      waits++;
    end while (!pready && waits < 8);
    check("pready_latency", 32'(waits), 32'd1);
    rd  = prdata;
    err = pslverr;
    if (w && !x_err) begin
      cm_valid = 1'b1; cm_addr = a; cm_data = d;
    end
    ev_dir = ev_cmt;
    @(posedge clk); @(negedge clk);
    cm_valid = 1'b0; ev_dir = '0; psel = 1'b0; penable = 1'b0;
    check("pready_drop", 32'(pready), 32'h0);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] rd, xr;
    bit err, xe;
    apb_xfer(1'b0, a, 32'h0, 32'h0, rd, err, xe, xr);
    check({name, "_rdata"}, rd, exp);
    check({name, "_err"}, 32'(err), 32'h0);
  endtask

  task automatic wr_chk(input string name, input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] ev_cmt);
    logic [31:0] rd, xr;
    bit err, xe;
    apb_xfer(1'b1, a, d, ev_cmt, rd, err, xe, xr);
    check({name, "_err"}, 32'(err), 32'h0);
  endtask

  initial begin
    logic [31:0] rd, xr, d;
    logic [7:0]  a;
    bit          err, xe, w;

    vecs = '{
      '{1'b0, 8'h00, 32'h0, 32'h0, 1'b0},
      '{1'b0, 8'h04, 32'h0, 32'h0, 1'b0},
      '{1'b0, 8'h08, 32'h0, 32'h0, 1'b0},
      '{1'b0, 8'h0C, 32'h0, 32'h0, 1'b0},
      '{1'b0, 8'h10, 32'h0, 32'h0, 1'b0},
      '{1'b0, 8'h14, 32'h0, 32'h0, 1'b0},
      '{1'b0, 8'h18, 32'h0, 32'h0, 1'b0},
      '{1'b0, 8'h1C, 32'h0, 32'h0, 1'b0},
      '{1'b0, 8'h20, 32'h0, 32'h0, 1'b0},
      '{1'b1, 8'h20, 32'hFFFF_FFFF, 32'h0, 1'b1},
      '{1'b0, 8'h24, 32'h0, 32'h0, 1'b1},
      '{1'b1, 8'h02, 32'h0000_00FF, 32'h0, 1'b1},
      '{1'b0, 8'h01, 32'h0, 32'h0, 1'b1},
      '{1'b1, 8'h40, 32'h0000_0001, 32'h0, 1'b1},
      '{1'b0, 8'h04, 32'h0, 32'h0, 1'b0},
      '{1'b0, 8'h00, 32'h0, 32'h0, 1'b0},
      '{1'b1, 8'h1C, 32'hFFFF_FF5A, 32'h0, 1'b0},
      '{1'b0, 8'h1C, 32'h0, 32'h5A, 1'b0},
      '{1'b1, 8'h1C, 32'h0, 32'h0, 1'b0},
      '{1'b1, 8'h00, 32'h0000_00FF, 32'h0, 1'b0},
      '{1'b0, 8'h00, 32'h0, 32'h0, 1'b0},
      '{1'b1, 8'h0C, 32'h0000_000F, 32'h0, 1'b0},
      '{1'b0, 8'h0C, 32'h0, 32'h0F, 1'b0}
    };

    repeat (3) @(negedge clk);
    check("reset_pready", 32'(pready), 32'h0);
    check("reset_prdata", prdata, 32'h0);
    check("reset_pslverr", 32'(pslverr), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_irq_any", 32'(irq_any), 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Register map, error accesses and width masking.
    for (int i = 0; i < NV; i++) begin
      apb_xfer(vecs[i].w, vecs[i].a, vecs[i].d, 32'h0, rd, err, xe, xr);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
    end

    // Event on ch1 bit 2 with ENABLE[1]=0x0F.
    ev_dir = 32'h0000_0400;
    @(negedge clk);
    ev_dir = '0;
    check("ev_irq_early", 32'(irq), 32'h0);
    @(negedge clk);
    check("ev_irq", 32'(irq), 32'h2);
    check("ev_irq_any", 32'(irq_any), 32'h1);
    rd_chk("ev_status1", 8'h08, 32'h04);
    rd_chk("ev_pending", 8'h20, 32'h2);

    // W1C coinciding with the same event: set wins.
    wr_chk("w1c_race", 8'h08, 32'h04, 32'h0000_0400);
    rd_chk("w1c_race_status", 8'h08, 32'h04);
    check("w1c_race_irq", 32'(irq), 32'h2);
    wr_chk("w1c_clear", 8'h08, 32'h04, 32'h0);
    check("w1c_irq_hold", 32'(irq), 32'h2);
    @(negedge clk);
    check("w1c_irq_fall", 32'(irq), 32'h0);
    check("w1c_irq_any_fall", 32'(irq_any), 32'h0);
    rd_chk("w1c_status", 8'h08, 32'h0);
    rd_chk("w1c_pending", 8'h20, 32'h0);

    // Masked status, then enable.
    ev_dir = 32'h0000_0080;
    @(negedge clk);
    ev_dir = '0;
    @(negedge clk);
    @(negedge clk);
    check("masked_irq", 32'(irq), 32'h0);
    rd_chk("masked_status0", 8'h00, 32'h80);
    wr_chk("enable0", 8'h04, 32'h80, 32'h0);
    check("enable0_irq_hold", 32'(irq), 32'h0);
    @(negedge clk);
    check("enable0_irq", 32'(irq), 32'h1);
    check("enable0_irq_any", 32'(irq_any), 32'h1);
    wr_chk("disable0", 8'h04, 32'h0, 32'h0);
    rd_chk("status_kept", 8'h00, 32'h80);
    wr_chk("clear0", 8'h00, 32'h80, 32'h0);
    rd_chk("clear0_status", 8'h00, 32'h0);

    // psel dropped during the wait state.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h14; pwdata = 32'hFF;
    @(negedge clk);
    psel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_pready", 32'(pready), 32'h0);
    end
    rd_chk("abort_enable2", 8'h14, 32'h0);

    // Reset asserted during DONE of a write.
    wr_chk("pre_reset_en3", 8'h1C, 32'h01, 32'h0);
    ev_dir = 32'h0100_0000;
    @(negedge clk);
    ev_dir = '0;
    @(negedge clk);
    check("pre_reset_irq", 32'(irq), 32'h8);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h14; pwdata = 32'hFF;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    check("done_before_reset", 32'(pready), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_pready", 32'(pready), 32'h0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_pslverr", 32'(pslverr), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_irq_any", 32'(irq_any), 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("rst_enable2", 8'h14, 32'h0);
    rd_chk("rst_enable3", 8'h1C, 32'h0);
    rd_chk("rst_status3", 8'h18, 32'h0);
    rd_chk("rst_pending", 8'h20, 32'h0);

    // Randomized traffic with random events against the model.
    rand_ev = 1'b1;
    for (int it = 0; it < 1500; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end else begin
        a = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'(4 * $urandom_range(0, 9));
        w = 1'($urandom_range(0, 1));
        d = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
        apb_xfer(w, a, d, 32'h0, rd, err, xe, xr);
        check("rand_rdata", rd, xr);
        check("rand_err", 32'(err), 32'(xe));
      end
    end
    rand_ev = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
